// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC sequencer: FSM state encoding and
// the tick-count / counter-width helpers.
// Latency: n/a (types and constant functions only). Backpressure: n/a.
package crc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } crc_state_t;

    // Message bits plus the augmenting zero bits (divisor degree).
    function automatic int crc_n_ticks(input int data_w, input int div_w);
        return data_w + div_w - 1;
    endfunction

    // Wide enough to hold N_TICKS itself (counter overshoots by one).
    function automatic int crc_cnt_width(input int data_w, input int div_w);
        return $clog2(crc_n_ticks(data_w, div_w) + 1);
    endfunction

endpackage

// File: rtl/crc_seq_ctrl_if.sv
// Bundle of all handshake, datapath-control and result signals of the CRC
// sequencer. Latency: n/a (wires). Backpressure: valid/ready on both sides.
// Ports: in_* message stream, abort, lfsr_clear/shift_en/shift_bit/crc_rem
// to/from the CRC datapath, out_* result stream, busy status.
interface crc_seq_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DIV_WIDTH  = 5
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  abort;
    logic                  lfsr_clear;
    logic                  shift_en;
    logic                  shift_bit;
    logic [DIV_WIDTH-2:0]  crc_rem;
    logic                  out_valid;
    logic [DIV_WIDTH-2:0]  out_crc;
    logic                  out_ready;
    logic                  busy;

    // Environment side: message source, datapath and result consumer.
    modport master (
        output in_valid, in_data, abort, crc_rem, out_ready,
        input  in_ready, lfsr_clear, shift_en, shift_bit, out_valid, out_crc, busy
    );

    // Controller side.
    modport slave (
        input  in_valid, in_data, abort, crc_rem, out_ready,
        output in_ready, lfsr_clear, shift_en, shift_bit, out_valid, out_crc, busy
    );
endinterface

// File: rtl/crc_tick_cnt.sv
// Shift-tick counter with synchronous clear, enable and terminal-count flag.
// Latency: count updates one cycle after i_en/i_clr. Backpressure: none.
// Ports: i_clr (priority over i_en), i_en, o_tc high while count == TC_VAL.
module crc_tick_cnt #(
    parameter int CNT_W  = 5,
    parameter int TC_VAL = 19
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == CNT_W'(TC_VAL));
endmodule

// File: rtl/crc_seq_ctrl.sv
// Sequencer feeding a message word MSB-first plus zero padding into a serial
// CRC datapath, then presenting the captured remainder.
// Latency: handshake in cycle 0 -> out_valid in cycle N_TICKS+3.
// Backpressure: one job at a time; in_ready low while busy, result held until out_ready.
// Ports: clk, rst_n (async active-low), s_bus (controller side of crc_seq_ctrl_if).
module crc_seq_ctrl
    import crc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DIV_WIDTH  = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    crc_seq_ctrl_if.slave  s_bus
);
    localparam int N_TICKS = crc_n_ticks(DATA_WIDTH, DIV_WIDTH);
    localparam int CNT_W   = crc_cnt_width(DATA_WIDTH, DIV_WIDTH);

    crc_state_t            r_state;
    crc_state_t            w_next;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DIV_WIDTH-2:0]  r_out_crc;
    logic                  w_in_ready;
    logic                  w_hs;
    logic                  w_cnt_clr;
    logic                  w_cnt_en;
    logic                  w_cnt_tc;

    // abort gates acceptance so it always wins over a simultaneous in_valid.
    assign w_in_ready = (r_state == ST_IDLE) & ~s_bus.abort;
    assign w_hs       = s_bus.in_valid & w_in_ready;

    crc_tick_cnt #(
        .CNT_W  (CNT_W),
        .TC_VAL (N_TICKS - 1)
    ) u_tick_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_tc  (w_cnt_tc)
    );

    always_comb begin
        w_next    = r_state;
        w_cnt_clr = 1'b0;
        w_cnt_en  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) w_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_cnt_clr = 1'b1;
                w_next    = ST_SHIFT;
            end
            ST_SHIFT: begin
                w_cnt_en = 1'b1;
                if (w_cnt_tc) w_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_next = ST_DONE;
            end
            ST_DONE: begin
                if (s_bus.out_ready) w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (s_bus.abort) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Left shift with zero fill: after the message bits are consumed the MSB
    // naturally supplies the DIV_WIDTH-1 augmenting zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= '0;
        end else if (w_hs) begin
            r_shreg <= s_bus.in_data;
        end else if (r_state == ST_SHIFT) begin
            r_shreg <= {r_shreg[DATA_WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_crc <= '0;
        end else if (r_state == ST_CAPTURE) begin
            r_out_crc <= s_bus.crc_rem;
        end
    end

    // All datapath controls decode from the registered state only.
    assign s_bus.in_ready   = w_in_ready;
    assign s_bus.lfsr_clear = (r_state == ST_CLEAR);
    assign s_bus.shift_en   = (r_state == ST_SHIFT);
    assign s_bus.shift_bit  = (r_state == ST_SHIFT) & r_shreg[DATA_WIDTH-1];
    assign s_bus.out_valid  = (r_state == ST_DONE);
    assign s_bus.out_crc    = r_out_crc;
    assign s_bus.busy       = (r_state != ST_IDLE);
endmodule

// File: tb/tb_crc_seq_ctrl.sv
// Directed bench for crc_seq_ctrl with a serial CRC-4 (x^4+x+1) datapath
// model driving crc_rem. Latency: n/a. Backpressure: driven per scenario.
module tb_crc_seq_ctrl;
    localparam int DW = 16;
    localparam int VW = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    crc_seq_ctrl_if #(.DATA_WIDTH(DW), .DIV_WIDTH(VW)) bus ();

    crc_seq_ctrl #(.DATA_WIDTH(DW), .DIV_WIDTH(VW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_bus (bus)
    );

    always #5 clk = ~clk;

    // Serial long-division datapath, generator 5'b10011.
    logic [3:0] model_rem = 4'h0;
    always @(posedge clk) begin
        if (bus.lfsr_clear)
            model_rem <= 4'h0;
        else if (bus.shift_en)
            model_rem <= {model_rem[2:0], bus.shift_bit} ^ (model_rem[3] ? 4'b0011 : 4'b0000);
    end
    assign bus.crc_rem = model_rem;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake a word; returns in cycle 1 (CLEAR) relative to the handshake.
    task automatic start_job(input logic [15:0] d);
        int n;
        n = 0;
        while (!bus.in_ready && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL start_job_timeout: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        while (!bus.out_valid && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (!bus.out_valid) begin
            errors++;
            $display("FAIL wait_out_valid_timeout: out_valid=%b required 1", bus.out_valid);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({bus.busy, bus.lfsr_clear, bus.shift_en, bus.shift_bit, bus.out_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy/clr/sh_en/sh_bit/vld=%b required 00000",
                     {bus.busy, bus.lfsr_clear, bus.shift_en, bus.shift_bit, bus.out_valid});
        end
        checks++;
        if (bus.out_crc !== 4'h0) begin
            errors++;
            $display("FAIL reset_out_crc: got %h required 0", bus.out_crc);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_latency();
        logic [19:0] stream;
        stream = 20'hA5A50;
        bus.out_ready = 1'b1;
        start_job(16'hA5A5);
        for (int c = 1; c <= 23; c++) begin
            if (c > 1) tick();
            checks++;
            if (bus.lfsr_clear !== (c == 1)) begin
                errors++;
                $display("FAIL lat_lfsr_clear c=%0d: got %b required %b", c, bus.lfsr_clear, (c == 1));
            end
            checks++;
            if (bus.shift_en !== (c >= 2 && c <= 21)) begin
                errors++;
                $display("FAIL lat_shift_en c=%0d: got %b required %b", c, bus.shift_en, (c >= 2 && c <= 21));
            end
            checks++;
            if (c >= 2 && c <= 21) begin
                if (bus.shift_bit !== stream[21-c]) begin
                    errors++;
                    $display("FAIL lat_shift_bit c=%0d: got %b required %b", c, bus.shift_bit, stream[21-c]);
                end
            end else if (bus.shift_bit !== 1'b0) begin
                errors++;
                $display("FAIL lat_shift_bit_idle c=%0d: got %b required 0", c, bus.shift_bit);
            end
            checks++;
            if (bus.out_valid !== (c == 23)) begin
                errors++;
                $display("FAIL lat_out_valid c=%0d: got %b required %b", c, bus.out_valid, (c == 23));
            end
        end
        checks++;
        if (bus.out_crc !== 4'hA) begin
            errors++;
            $display("FAIL lat_out_crc: got %h required a", bus.out_crc);
        end
        checks++;
        if (bus.out_crc !== model_rem) begin
            errors++;
            $display("FAIL lat_out_crc_model: got %h model %h", bus.out_crc, model_rem);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL lat_return_idle: busy=%b in_ready=%b required 0/1", bus.busy, bus.in_ready);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        start_job(16'hFFFF);
        wait_out_valid();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_crc !== 4'h3) begin
                errors++;
                $display("FAIL bp_hold i=%0d: out_valid=%b out_crc=%h required 1/3", i, bus.out_valid, bus.out_crc);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: busy=%b out_valid=%b required 0/0", bus.busy, bus.out_valid);
        end
    endtask

    task automatic test_abort_shift();
        bit seen_valid;
        bus.out_ready = 1'b1;
        start_job(16'hA5A5);
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (bus.shift_en !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_shift: shift_en=%b required 1", bus.shift_en);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.shift_en !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_shift_idle: busy=%b shift_en=%b in_ready=%b required 0/0/1",
                     bus.busy, bus.shift_en, bus.in_ready);
        end
        seen_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.out_valid) seen_valid = 1'b1;
            tick();
        end
        checks++;
        if (seen_valid) begin
            errors++;
            $display("FAIL abort_no_result: out_valid seen=1 required 0");
        end
    endtask

    task automatic test_abort_idle();
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hFFFF;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle_in_ready: got %b required 0", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.lfsr_clear !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle_state: busy=%b lfsr_clear=%b required 0/0", bus.busy, bus.lfsr_clear);
        end
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_capture();
        bit seen_valid;
        bus.out_ready = 1'b1;
        start_job(16'h1234);
        for (int i = 0; i < 21; i++) tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.shift_en !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstcap_pre: busy=%b shift_en=%b out_valid=%b required 1/0/0",
                     bus.busy, bus.shift_en, bus.out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.lfsr_clear, bus.shift_en, bus.shift_bit, bus.out_valid} !== 5'b0) begin
            errors++;
            $display("FAIL rstcap_outputs: busy/clr/sh_en/sh_bit/vld=%b required 00000",
                     {bus.busy, bus.lfsr_clear, bus.shift_en, bus.shift_bit, bus.out_valid});
        end
        checks++;
        if (bus.out_crc !== 4'h0) begin
            errors++;
            $display("FAIL rstcap_out_crc: got %h required 0", bus.out_crc);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstcap_in_ready: got %b required 1", bus.in_ready);
        end
        seen_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.out_valid) seen_valid = 1'b1;
            tick();
        end
        checks++;
        if (seen_valid) begin
            errors++;
            $display("FAIL rstcap_no_result: out_valid seen=1 required 0");
        end
    endtask

    task automatic test_back_to_back();
        int  acc_cyc;
        int  hs_cyc;
        bit  busy_ready;
        bus.out_ready = 1'b1;
        start_job(16'h0000);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hFFFF;
        acc_cyc    = -1;
        hs_cyc     = -1;
        busy_ready = 1'b0;
        for (int cyc = 0; cyc < 80 && hs_cyc < 0; cyc++) begin
            if (bus.busy && bus.in_ready) busy_ready = 1'b1;
            if (bus.out_valid && acc_cyc < 0) begin
                acc_cyc = cyc;
                checks++;
                if (bus.out_crc !== 4'h0 || bus.out_crc !== model_rem) begin
                    errors++;
                    $display("FAIL b2b_first_crc: got %h required 0 model %h", bus.out_crc, model_rem);
                end
            end
            if (bus.in_valid && bus.in_ready && acc_cyc >= 0) hs_cyc = cyc;
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (acc_cyc < 0 || hs_cyc != acc_cyc + 1) begin
            errors++;
            $display("FAIL b2b_second_hs: accept cycle %0d handshake cycle %0d required accept+1", acc_cyc, hs_cyc);
        end
        checks++;
        if (busy_ready) begin
            errors++;
            $display("FAIL b2b_in_ready_busy: in_ready seen while busy, required never");
        end
        wait_out_valid();
        checks++;
        if (bus.out_crc !== 4'h3 || bus.out_crc !== model_rem) begin
            errors++;
            $display("FAIL b2b_second_crc: got %h required 3 model %h", bus.out_crc, model_rem);
        end
        tick();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_latency();
        test_backpressure();
        test_abort_shift();
        test_abort_idle();
        test_reset_capture();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/crc_seq_ctrl.md
CRC_SEQ_CTRL -- requirements
Module: crc_seq_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16: message word width in bits (>=2).
REQ-002 Parameter DIV_WIDTH, default 5: divisor (generator polynomial) width in bits (>=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  message word offered.
REQ-006 in_data  input  DATA_WIDTH  message word.
REQ-007 in_ready  output  1  controller can accept a word.
REQ-008 abort  input  1  synchronous cancel of the current job.
REQ-009 lfsr_clear  output  1  clears the CRC datapath remainder register.
REQ-010 shift_en  output  1  advances the CRC datapath one bit.
REQ-011 shift_bit  output  1  serial bit fed to the datapath.
REQ-012 crc_rem  input  DIV_WIDTH-1  current datapath remainder.
REQ-013 out_valid  output  1  CRC result available.
REQ-014 out_crc  output  DIV_WIDTH-1  captured CRC result.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 N_TICKS = DATA_WIDTH+DIV_WIDTH-1; tick counter width = $clog2(N_TICKS+1).
REQ-018 FSM states: IDLE, CLEAR, SHIFT, CAPTURE, DONE.
REQ-019 IDLE: in_ready = ~abort; a handshake (in_valid & in_ready) loads in_data into the shift register and moves to CLEAR.
REQ-020 CLEAR, one cycle: lfsr_clear=1; counter=0; next state SHIFT.
REQ-021 SHIFT, exactly N_TICKS cycles: shift_en=1; counter increments every cycle.
REQ-022 SHIFT feed: shift_bit = in_data bits MSB first for counter 0..DATA_WIDTH-1, then 0 for counter DATA_WIDTH..N_TICKS-1.
REQ-023 SHIFT to CAPTURE when counter == N_TICKS-1.
REQ-024 CAPTURE, one cycle: out_crc <= crc_rem; next state DONE.
REQ-025 DONE: out_valid=1; out_crc stable; on out_ready, move to IDLE the next cycle.
REQ-026 Latency: handshake in cycle 0 -> out_valid first high in cycle N_TICKS+3 (23 at defaults).
REQ-027 Backpressure: out_valid holds with unchanged out_crc for any number of cycles with out_ready=0.
REQ-028 in_ready=0 outside IDLE; no input acceptance while busy; in_valid outside IDLE has no effect.
REQ-029 abort in any state: next state IDLE; lfsr_clear, shift_en and out_valid low from the next cycle on.
REQ-030 abort and in_valid together in IDLE: abort wins; word not accepted.
REQ-031 lfsr_clear, shift_en and shift_bit are 0 in every state not named for them above.
REQ-032 out_ready outside DONE is ignored.

Reset
REQ-033 rst_n low: state=IDLE, counter=0, shift register=0, out_crc=0, out_valid=0, lfsr_clear=0, shift_en=0, shift_bit=0, busy=0; in_ready=1 after release.
REQ-034 Reset mid-job discards the job; no partial result is ever presented.

Structure
REQ-035 Shared package crc_pkg holds the state enumeration and the N_TICKS / counter-width constant functions.
REQ-036 The tick counter is one sub-module crc_tick_cnt: synchronous clear, enable, terminal-count flag.
REQ-037 The shift register and FSM live in crc_seq_ctrl; outputs are decoded from registered state only (no combinational path from in_valid to any output except in_ready via abort).

Verification
REQ-038 Defaults, in_data=16'hA5A5, out_ready=1 -> lfsr_clear in cycle 1; shift_en high cycles 2..21; shift_bit sequence 1010010110100101 then 0000; out_valid in cycle 23.
REQ-039 out_ready held 0 for 10 cycles in DONE -> out_valid and out_crc constant for all 10 cycles; IDLE one cycle after out_ready=1.
REQ-040 abort asserted in SHIFT at counter=7 -> next cycle IDLE, shift_en=0, in_ready=1, no out_valid.
REQ-041 abort=1 and in_valid=1 in IDLE -> no handshake, state stays IDLE.
REQ-042 rst_n low in CAPTURE -> all outputs at reset values immediately, out_valid never asserted.
REQ-043 Back-to-back jobs 16'h0000 then 16'hFFFF with a reference CRC datapath model -> out_crc matches the model for both; second handshake no earlier than one cycle after the first result is accepted.
